clock_bringup_sequencer: RTL and testbench
==========================================

// Module: clock_bringup_sequencer
// PURPOSE
//  Generalised successor to the fixed PLL->DCM->DCM lock chain. Sequences N cascaded clock generators
//  (PLL/DCM stages): holds each stage in reset until its upstream stage is stably locked, detects
//  lock timeouts and retries, recovers from lock loss at any stage, reports sticky status.
//  Runs on the free-running board reference clock. Drives the active-high RST pins of the primitives.
// PARAMETERS
//  N_STAGES      3   number of cascaded clock generators (stage 0 = nearest the board clock)
//  SYNC_STAGES   2   synchroniser depth for each lock input (>=2)
//  HOLD_CYCLES   4   reset pulse width applied before (re)starting a stage (>=1)
//  LOCK_TIMEOUT  4096  cycles allowed in WAIT for a stage to assert lock (>=2)
//  STABLE_CYCLES 64  consecutive locked cycles required before advancing (>=1)
//  MAX_RETRIES   3   timeouts tolerated per stage before FAIL
// PORTS
//  clk          in   1        free-running reference clock
//  rst_n        in   1        async reset, active-low
//  enable       in   1        level: 1 = bring up clocks, 0 = hold all stages in reset
//  clear_fail   in   1        pulse: leave FAIL, clear sticky status
//  lock_async   in   N_STAGES raw LOCKED outputs of the primitives (asynchronous to clk)
//  stage_rst    out  N_STAGES active-high reset to each primitive
//  locked       out  1        all stages locked and stable
//  busy         out  1        sequencing in progress (HOLD/WAIT/STABLE)
//  failed       out  1        retries exhausted
//  fail_stage   out  SW       stage index that failed, SW = max(1,$clog2(N_STAGES))
//  retry_cnt    out  RW       timeouts on current stage, RW = $clog2(MAX_RETRIES+1)
//  lost_lock    out  N_STAGES sticky: stage k lost lock after having been stable
// BEHAVIOUR
//  - Reset (rst_n=0, async): stage_rst all 1; locked, busy, failed, fail_stage, retry_cnt, lost_lock 0;
//    synchroniser flops 0; state IDLE, idx 0. All outputs registered.
//  - lock_s = lock_async through SYNC_STAGES flops; all decisions use lock_s only.
//  - IDLE: stage_rst all 1. enable=1 -> HOLD, idx=0, cnt=0.
//  - HOLD: stage_rst[j]=1 for j>=idx, 0 for j<idx. After HOLD_CYCLES cycles -> WAIT, cnt=0;
//    stage_rst[idx] reads 0 from first WAIT cycle.
//  - WAIT: lock_s[idx]=1 -> STABLE, cnt=0. Else at cnt==LOCK_TIMEOUT-1: if retry_cnt==MAX_RETRIES
//    -> FAIL, fail_stage=idx; else retry_cnt++, -> HOLD (same idx).
//  - STABLE: lock_s[idx]=0 -> WAIT, cnt=0 (timeout restarts). At cnt==STABLE_CYCLES-1: retry_cnt=0;
//    idx==N_STAGES-1 -> RUN, else idx++, -> WAIT (downstream resets already held, no HOLD).
//  - RUN: locked=1, busy=0.
//  - Lock loss (WAIT/STABLE/RUN): any k<idx (all k in RUN) with lock_s[k]=0 -> lost_lock[k] set,
//    idx=lowest such k, -> HOLD, locked=0 next cycle. Does not increment retry_cnt. Wins over
//    simultaneous timeout/advance.
//  - FAIL: stage_rst all 1, failed=1, enable ignored. clear_fail -> IDLE; clears failed, fail_stage,
//    retry_cnt, lost_lock. clear_fail in other states clears lost_lock only.
//  - enable=0 in any state except FAIL -> IDLE next cycle (stage_rst all 1, retry_cnt 0; lost_lock kept).
//  - Counters: cnt width $clog2(max(HOLD,TIMEOUT,STABLE)); no wrap possible, compares are exact.
// STRUCTURE
//  - clk_seq_pkg: state encoding (IDLE,HOLD,WAIT,STABLE,RUN,FAIL), width helper functions.
//  - Sub-module lock_sync #(WIDTH,STAGES): N-bit multi-flop synchroniser, async active-low reset.
//  - Top: FSM + cnt + idx + retry_cnt + registered output decode.
// TESTING (N=3, SYNC=2, HOLD=4, TIMEOUT=16, STABLE=8, MAX_RETRIES=2; model locks k cycles after RST falls)
//  1 Normal: enable=1, each lock rises 5 cycles after its rst falls -> stage_rst 111->110->100->000
//    in order, each step >=8+2 cycles apart; locked=1, busy=0, lost_lock=000.
//  2 Timeout: stage 1 never locks -> stage_rst[1] re-pulses 4 cycles after every 16-cycle wait,
//    retry_cnt 1,2, then failed=1, fail_stage=1, stage_rst=111; clear_fail -> IDLE, restart.
//  3 Loss in RUN: drop lock_async[0] for 4 cycles -> lost_lock=001, locked=0 within 3 cycles,
//    stage_rst=111 then full resequence to locked=1; lost_lock stays 001 until clear_fail.
//  4 Glitch in STABLE: stage 2 lock drops at STABLE cnt 5 -> back to WAIT, locked only after 8
//    further consecutive locked cycles; retry_cnt unchanged.
//  5 enable=0 mid-WAIT (idx=1) -> next cycle stage_rst=111, busy=0; enable=1 -> HOLD from stage 0.
//  6 rst_n low mid-RUN, asynchronous to clk -> all outputs at reset values before next clk edge.

Source files
------------

// File: rtl/clk_seq_pkg.sv
// Shared definitions for the clock bring-up sequencer: FSM state encoding
// and the width helpers used to size ports and counters from parameters.
package clk_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HOLD   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STABLE = 3'd3,
    ST_RUN    = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  // Width of a stage index; a single stage still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must reach m (inclusive).
  function automatic int retry_width(input int m);
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction

  // Width of the shared phase counter, sized for the longest phase.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/clock_bringup_sequencer_lock_sync.sv
// Multi-flop synchroniser bringing the raw LOCKED pins into the clk domain.
// Each bit is synchronised independently; bits may be skewed by a cycle.
module lock_sync #(
  parameter int WIDTH  = 3,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sync_q [STAGES];

  // Shift the asynchronous inputs through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= din;
      for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/clock_bringup_sequencer.sv
// Brings up a cascade of PLL/DCM stages one at a time: each stage is held in
// reset until everything upstream is stably locked, lock timeouts are retried
// a bounded number of times, and lock loss anywhere restarts from the lowest
// stage that dropped. All outputs are registered.
module clock_bringup_sequencer
  import clk_seq_pkg::*;
#(
  parameter int N_STAGES      = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int HOLD_CYCLES   = 4,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 64,
  parameter int MAX_RETRIES   = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic                                clear_fail,
  input  logic [N_STAGES-1:0]                 lock_async,
  output logic [N_STAGES-1:0]                 stage_rst,
  output logic                                locked,
  output logic                                busy,
  output logic                                failed,
  output logic [idx_width(N_STAGES)-1:0]      fail_stage,
  output logic [retry_width(MAX_RETRIES)-1:0] retry_cnt,
  output logic [N_STAGES-1:0]                 lost_lock
);

  localparam int SW = idx_width(N_STAGES);
  localparam int RW = retry_width(MAX_RETRIES);
  localparam int CW = cnt_width(HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] IDX_LAST    = SW'(N_STAGES - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

  logic [N_STAGES-1:0] lock_s;
  state_t              state;
  logic [SW-1:0]       idx;
  logic [CW-1:0]       cnt;
  logic [N_STAGES-1:0] loss_vec;
  logic                loss;
  logic [SW-1:0]       loss_idx;

  lock_sync #(
    .WIDTH  (N_STAGES),
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (lock_async),
    .dout  (lock_s)
  );

  // Reset pattern seen by the primitives in a given state for current stage i.
  // Stages below i run; stage i runs once its reset pulse has completed.
  function automatic logic [N_STAGES-1:0] rst_mask(input state_t st, input logic [SW-1:0] i);
    logic [N_STAGES-1:0] m;
    m = '1;
    for (int k = 0; k < N_STAGES; k++) begin
      case (st)
        ST_HOLD:             m[k] = (k >= int'(i));
        ST_WAIT, ST_STABLE:  m[k] = (k > int'(i));
        ST_RUN:              m[k] = 1'b0;
        default:             m[k] = 1'b1;
      endcase
    end
    return m;
  endfunction

  // Upstream lock loss: stages already released (all of them in RUN) whose
  // synchronised lock has dropped; restart from the lowest one.
  always_comb begin
    loss_vec = '0;
    loss_idx = '0;
    for (int k = 0; k < N_STAGES; k++) begin
      if ((state == ST_RUN) || (((state == ST_WAIT) || (state == ST_STABLE)) && (k < int'(idx))))
        loss_vec[k] = ~lock_s[k];
    end
    for (int k = N_STAGES - 1; k >= 0; k--) begin
      if (loss_vec[k]) loss_idx = SW'(k);
    end
    loss = |loss_vec;
  end

  // Sequencer FSM with phase counter, stage index and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      cnt        <= '0;
      retry_cnt  <= '0;
      stage_rst  <= '1;
      locked     <= 1'b0;
      busy       <= 1'b0;
      failed     <= 1'b0;
      fail_stage <= '0;
      lost_lock  <= '0;
    end else begin
      if (clear_fail) lost_lock <= '0;

      if ((state != ST_FAIL) && !enable) begin
        state     <= ST_IDLE;
        idx       <= '0;
        cnt       <= '0;
        retry_cnt <= '0;
        stage_rst <= '1;
        locked    <= 1'b0;
        busy      <= 1'b0;
      end else if (loss) begin
        // Lock loss overrides any timeout or advance in the same cycle.
        state     <= ST_HOLD;
        idx       <= loss_idx;
        cnt       <= '0;
        lost_lock <= (clear_fail ? '0 : lost_lock) | loss_vec;
        stage_rst <= rst_mask(ST_HOLD, loss_idx);
        locked    <= 1'b0;
        busy      <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (enable) begin
              state     <= ST_HOLD;
              idx       <= '0;
              cnt       <= '0;
              stage_rst <= rst_mask(ST_HOLD, '0);
              busy      <= 1'b1;
            end
          end
          ST_HOLD: begin
            if (cnt == HOLD_LAST) begin
              state     <= ST_WAIT;
              cnt       <= '0;
              stage_rst <= rst_mask(ST_WAIT, idx);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_WAIT: begin
            if (lock_s[idx]) begin
              state <= ST_STABLE;
              cnt   <= '0;
            end else if (cnt == TMO_LAST) begin
              cnt <= '0;
              if (retry_cnt == RETRY_MAX) begin
                state      <= ST_FAIL;
                fail_stage <= idx;
                stage_rst  <= '1;
                busy       <= 1'b0;
                failed     <= 1'b1;
              end else begin
                state     <= ST_HOLD;
                retry_cnt <= retry_cnt + 1'b1;
                stage_rst <= rst_mask(ST_HOLD, idx);
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_STABLE: begin
            if (!lock_s[idx]) begin
              // A glitch restarts the timeout window for this stage.
              state <= ST_WAIT;
              cnt   <= '0;
            end else if (cnt == STABLE_LAST) begin
              retry_cnt <= '0;
              cnt       <= '0;
              if (idx == IDX_LAST) begin
                state     <= ST_RUN;
                stage_rst <= '0;
                locked    <= 1'b1;
                busy      <= 1'b0;
              end else begin
                // Downstream stages are still in reset, so no HOLD needed.
                state     <= ST_WAIT;
                idx       <= idx + 1'b1;
                stage_rst <= rst_mask(ST_WAIT, idx + 1'b1);
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_RUN: begin
            locked <= 1'b1;
          end
          ST_FAIL: begin
            if (clear_fail) begin
              state      <= ST_IDLE;
              idx        <= '0;
              cnt        <= '0;
              retry_cnt  <= '0;
              failed     <= 1'b0;
              fail_stage <= '0;
            end
          end
          default: begin
            state     <= ST_IDLE;
            stage_rst <= '1;
            locked    <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_bringup_sequencer.sv
// Bench for clock_bringup_sequencer: models the primitives (lock k cycles
// after reset falls), predicts outputs from the sequencing rules with a
// deadline-based reference model, and scoreboards every cycle.
module tb_clock_bringup_sequencer;

  localparam int N    = 3;
  localparam int SYNC = 2;
  localparam int HOLD = 4;
  localparam int TMO  = 16;
  localparam int STB  = 8;
  localparam int MAXR = 2;

  localparam int P_IDLE = 0, P_HOLD = 1, P_WAIT = 2, P_STABLE = 3, P_RUN = 4, P_FAIL = 5;

  typedef struct packed {
    logic [2:0] rst;
    logic       lk;
    logic       bsy;
    logic       fl;
    logic [1:0] fs;
    logic [1:0] rc;
    logic [2:0] lost;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       clear_fail = 1'b0;
  logic [2:0] lock_async = '0;
  logic [2:0] stage_rst;
  logic       locked, busy, failed;
  logic [1:0] fail_stage, retry_cnt;
  logic [2:0] lost_lock;

  clock_bringup_sequencer #(
    .N_STAGES(N), .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD),
    .LOCK_TIMEOUT(TMO), .STABLE_CYCLES(STB), .MAX_RETRIES(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear_fail(clear_fail),
    .lock_async(lock_async), .stage_rst(stage_rst), .locked(locked),
    .busy(busy), .failed(failed), .fail_stage(fail_stage),
    .retry_cnt(retry_cnt), .lost_lock(lost_lock)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state: phase, current stage, absolute deadline cycle.
  int       cyc, m_ph, m_idx, m_dl, m_ret, m_fs;
  bit [2:0] m_lost;
  bit [2:0] hist[$];
  int       pcnt[N], pdly[N], drop_tmr[N];
  bit       never_l[N], drop_l[N];
  obs_t     exp_q[$];
  obs_t     e_o, a_o;

  function automatic obs_t model_obs();
    obs_t o;
    o = '0;
    for (int k = 0; k < N; k++) begin
      if (m_ph == P_IDLE || m_ph == P_FAIL) o.rst[k] = 1'b1;
      else if (m_ph == P_HOLD)              o.rst[k] = (k >= m_idx);
      else if (m_ph == P_RUN)               o.rst[k] = 1'b0;
      else                                  o.rst[k] = (k > m_idx);
    end
    o.lk   = (m_ph == P_RUN);
    o.bsy  = (m_ph == P_HOLD || m_ph == P_WAIT || m_ph == P_STABLE);
    o.fl   = (m_ph == P_FAIL);
    o.fs   = 2'(m_fs);
    o.rc   = 2'(m_ret);
    o.lost = m_lost;
    return o;
  endfunction

  task automatic model_reset();
    cyc = 0; m_ph = P_IDLE; m_idx = 0; m_dl = 0; m_ret = 0; m_fs = 0; m_lost = '0;
    hist.delete();
    for (int i = 0; i <= SYNC; i++) hist.push_back(3'b000);
    for (int k = 0; k < N; k++) begin pcnt[k] = 0; drop_tmr[k] = 0; drop_l[k] = 0; end
    lock_async = '0;
  endtask

  task automatic model_step(input bit en, input bit clr);
    bit [2:0] ls;
    int lim, low;
    cyc++;
    hist.push_back(lock_async);
    ls = hist[hist.size() - 1 - SYNC];
    if (hist.size() > 8) void'(hist.pop_front());
    if (clr) m_lost = '0;
    if (m_ph != P_FAIL && !en) begin
      m_ph = P_IDLE; m_idx = 0; m_ret = 0;
    end else begin
      low = -1;
      if (m_ph == P_WAIT || m_ph == P_STABLE || m_ph == P_RUN) begin
        lim = (m_ph == P_RUN) ? N : m_idx;
        for (int k = 0; k < lim; k++)
          if (!ls[k]) begin m_lost[k] = 1'b1; if (low < 0) low = k; end
      end
      if (low >= 0) begin
        m_ph = P_HOLD; m_idx = low; m_dl = cyc + HOLD;
      end else begin
        case (m_ph)
          P_IDLE: begin m_ph = P_HOLD; m_idx = 0; m_dl = cyc + HOLD; end
          P_HOLD: if (cyc == m_dl) begin m_ph = P_WAIT; m_dl = cyc + TMO; end
          P_WAIT: begin
            if (ls[m_idx]) begin m_ph = P_STABLE; m_dl = cyc + STB; end
            else if (cyc == m_dl) begin
              if (m_ret == MAXR) begin m_ph = P_FAIL; m_fs = m_idx; end
              else begin m_ret++; m_ph = P_HOLD; m_dl = cyc + HOLD; end
            end
          end
          P_STABLE: begin
            if (!ls[m_idx]) begin m_ph = P_WAIT; m_dl = cyc + TMO; end
            else if (cyc == m_dl) begin
              m_ret = 0;
              if (m_idx == N - 1) m_ph = P_RUN;
              else begin m_idx++; m_ph = P_WAIT; m_dl = cyc + TMO; end
            end
          end
          P_FAIL: if (clr) begin m_ph = P_IDLE; m_idx = 0; m_ret = 0; m_fs = 0; m_lost = '0; end
          default: ;
        endcase
      end
    end
  endtask

  // Primitive behaviour: lock pdly cycles after its reset falls.
  task automatic prim_update(input obs_t o);
    for (int k = 0; k < N; k++) begin
      if (o.rst[k]) pcnt[k] = 0;
      else if (pcnt[k] < 100000) pcnt[k]++;
      lock_async[k] = !o.rst[k] && (pcnt[k] >= pdly[k]) && !never_l[k] && !drop_l[k];
    end
  endtask

  task automatic cycle();
    obs_t o;
    @(posedge clk);
    #1;
    model_step(enable, clear_fail);
    o = model_obs();
    exp_q.push_back(o);
    prim_update(o);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic pulse_clear();
    clear_fail = 1'b1; cycle(); clear_fail = 1'b0;
  endtask

  task automatic wait_phase(input int ph, input int ix, input int maxc, input string nm);
    int n;
    n = 0;
    while (!(m_ph == ph && (ix < 0 || m_idx == ix)) && n < maxc) begin cycle(); n++; end
    if (!(m_ph == ph && (ix < 0 || m_idx == ix))) begin
      total++; bad++;
      $display("FAIL wait_%s: no progress after %0d cycles, model phase=%0d idx=%0d", nm, n, m_ph, m_idx);
    end
  endtask

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stage_rst"}, int'(stage_rst), 7);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_failed"}, int'(failed), 0);
    chk({tag, "_fail_stage"}, int'(fail_stage), 0);
    chk({tag, "_retry_cnt"}, int'(retry_cnt), 0);
    chk({tag, "_lost_lock"}, int'(lost_lock), 0);
  endtask

  // Scoreboard monitor: compare every presented cycle against the model.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_o = exp_q.pop_front();
      a_o = {stage_rst, locked, busy, failed, fail_stage, retry_cnt, lost_lock};
      total++;
      if (a_o !== e_o) begin
        bad++;
        $display("FAIL outputs @%0t: got rst=%b lk=%b busy=%b fail=%b fs=%0d rc=%0d lost=%b expected rst=%b lk=%b busy=%b fail=%b fs=%0d rc=%0d lost=%b",
                 $time, a_o.rst, a_o.lk, a_o.bsy, a_o.fl, a_o.fs, a_o.rc, a_o.lost,
                 e_o.rst, e_o.lk, e_o.bsy, e_o.fl, e_o.fs, e_o.rc, e_o.lost);
      end
    end
  end

  initial begin
    for (int k = 0; k < N; k++) begin pdly[k] = 5; never_l[k] = 0; end
    model_reset();
    #2 rst_n = 1'b0;
    #20;
    chk_reset_outputs("por");
    @(negedge clk); #2 rst_n = 1'b1;

    // 1: normal bring-up
    enable = 1'b1;
    wait_phase(P_RUN, -1, 300, "normal");
    run(6);

    // 2: stage 1 never locks -> retries then FAIL; clear and restart
    enable = 1'b0; run(2);
    never_l[1] = 1; enable = 1'b1;
    wait_phase(P_FAIL, -1, 400, "timeout");
    enable = 1'b0; run(3); enable = 1'b1;
    pulse_clear();
    never_l[1] = 0;
    wait_phase(P_RUN, -1, 300, "recover");
    run(3);

    // 3: loss of stage 0 in RUN
    drop_l[0] = 1; run(4); drop_l[0] = 0;
    wait_phase(P_RUN, -1, 300, "reseq");
    run(4);
    pulse_clear();
    run(2);

    // 4: glitch on stage 2 while it is being qualified
    enable = 1'b0; run(2);
    for (int k = 0; k < N; k++) pdly[k] = $urandom_range(1, 8);
    enable = 1'b1;
    wait_phase(P_STABLE, 2, 300, "stable2");
    while (m_ph == P_STABLE && cyc != m_dl - STB + 1) cycle();
    drop_l[2] = 1; cycle(); drop_l[2] = 0;
    wait_phase(P_RUN, -1, 300, "glitch");
    run(3);

    // 5: enable dropped while waiting on stage 1
    enable = 1'b0; run(2); enable = 1'b1;
    wait_phase(P_WAIT, 1, 300, "wait1");
    run(2);
    enable = 1'b0; cycle(); enable = 1'b1;
    wait_phase(P_RUN, -1, 300, "reenable");

    // Randomised soak: lock drops, enable blips, clear pulses, slow locks
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 79) == 0) drop_tmr[$urandom_range(0, N-1)] = $urandom_range(1, 6);
      for (int k = 0; k < N; k++) drop_l[k] = (drop_tmr[k] > 0);
      if ($urandom_range(0, 199) == 0) begin
        enable = 1'b0;
        for (int k = 0; k < N; k++) pdly[k] = $urandom_range(1, 20);
      end else begin
        enable = 1'b1;
      end
      clear_fail = ($urandom_range(0, 149) == 0) || (m_ph == P_FAIL && $urandom_range(0, 9) == 0);
      cycle();
      clear_fail = 1'b0;
      for (int k = 0; k < N; k++) if (drop_tmr[k] > 0) drop_tmr[k]--;
    end
    for (int k = 0; k < N; k++) begin drop_tmr[k] = 0; drop_l[k] = 0; pdly[k] = 5; end
    enable = 1'b1;
    if (m_ph == P_FAIL) pulse_clear();
    wait_phase(P_RUN, -1, 400, "soak_end");
    run(2);

    // 6: asynchronous reset in RUN
    @(negedge clk);
    chk("run_locked", int'(locked), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    model_reset();
    @(negedge clk); #2 rst_n = 1'b1;
    wait_phase(P_RUN, -1, 300, "after_reset");
    run(3);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
